// File: rtl/product_reg_pkg.sv
// -----------------------------------------------------------------------------
// product_reg_pkg
//
// Shared definitions for the product-register arbiter slice.
//   X_WIDTH / Y_WIDTH : default widths of the two product fields
//   INIT_X / INIT_Y   : default field values loaded on reset and on clear
//   product_t         : packed {y, x} view of the product register (y in MSBs)
//   state_e           : arbiter FSM states
// -----------------------------------------------------------------------------
package product_reg_pkg;

    localparam int X_WIDTH = 8;
    localparam int Y_WIDTH = 4;

    localparam logic [X_WIDTH-1:0] INIT_X = 8'hde;
    localparam logic [Y_WIDTH-1:0] INIT_Y = 4'ha;

    typedef struct packed {
        logic [Y_WIDTH-1:0] y;
        logic [X_WIDTH-1:0] x;
    } product_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : product_reg_pkg

// File: rtl/product_rr_pick.sv
// -----------------------------------------------------------------------------
// product_rr_pick
//
// Combinational round-robin selector. Searches req_i starting at index ptr_i,
// wrapping modulo N_REQ, and reports the first asserted requester.
//
// Ports:
//   req_i  in  N_REQ  request vector
//   ptr_i  in  PTR_W  index with the highest priority this cycle
//   gnt_o  out N_REQ  one-hot winner (zero when no request)
//   idx_o  out PTR_W  encoded winner index (zero when no request)
//   any_o  out 1      at least one request present
// -----------------------------------------------------------------------------
module product_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int j;

    // Walk the offsets from the farthest to the nearest so that the candidate
    // closest to ptr_i is the last one written and therefore wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j[PTR_W-1:0];
                any_o    = 1'b1;
            end
        end
    end

endmodule : product_rr_pick

// File: rtl/product_reg_arbiter.sv
// -----------------------------------------------------------------------------
// product_reg_arbiter
//
// Round-robin arbiter in front of a shared {x, y} product register. At most one
// requester is granted per cycle; the granted fields are loaded at the next
// edge and O_valid pulses for one cycle. After each write the register can be
// held for HOLD_CYCLES cycles during which no grant is issued.
//
// Ports:
//   CLK          in   1               clock, rising edge
//   ASYNCRESETN  in   1               asynchronous active-low reset
//   req_valid    in   N_REQ           per-requester write request
//   req_ready    out  N_REQ           grant, one-hot or zero
//   req_x        in   N_REQ*X_WIDTH   packed x fields, lane i at [i*X_WIDTH +: X_WIDTH]
//   req_y        in   N_REQ*Y_WIDTH   packed y fields, same packing
//   clear        in   1               synchronous reload of INIT_X / INIT_Y
//   O_x          out  X_WIDTH         registered field x
//   O_y          out  Y_WIDTH         registered field y
//   O_valid      out  1               register was updated at the last edge
//   O_owner      out  clog2(N_REQ)    index of the last granted requester
//   busy         out  1               high while holding after a write
// -----------------------------------------------------------------------------
module product_reg_arbiter #(
    parameter int                  N_REQ       = 4,
    parameter int                  X_WIDTH     = product_reg_pkg::X_WIDTH,
    parameter int                  Y_WIDTH     = product_reg_pkg::Y_WIDTH,
    parameter logic [X_WIDTH-1:0]  INIT_X      = product_reg_pkg::INIT_X,
    parameter logic [Y_WIDTH-1:0]  INIT_Y      = product_reg_pkg::INIT_Y,
    parameter int                  HOLD_CYCLES = 2
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESETN,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*X_WIDTH-1:0]     req_x,
    input  logic [N_REQ*Y_WIDTH-1:0]     req_y,
    input  logic                         clear,
    output logic [X_WIDTH-1:0]           O_x,
    output logic [Y_WIDTH-1:0]           O_y,
    output logic                         O_valid,
    output logic [$clog2(N_REQ)-1:0]     O_owner,
    output logic                         busy
);

    import product_reg_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

    // Same {y, x} layout as product_t, sized by this instance's parameters.
    typedef struct packed {
        logic [Y_WIDTH-1:0] y;
        logic [X_WIDTH-1:0] x;
    } prod_reg_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    prod_reg_t        prod_q,  prod_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant_en;
    logic               hs;
    logic [X_WIDTH-1:0] sel_x;
    logic [Y_WIDTH-1:0] sel_y;

    product_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs && (HOLD_CYCLES > 0)) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Ready is gated by the reset pin itself so no grant leaks out while the
    // reset is asserted, even though the state register already reads IDLE.
    always_comb begin
        grant_en  = ASYNCRESETN && (state_q == IDLE) && !clear;
        req_ready = grant_en ? pick_gnt : '0;
        busy      = (state_q == HOLD);
    end

    assign hs = pick_any && |(req_valid & req_ready);

    // Lane mux for the winning requester's fields.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_x = req_x[i*X_WIDTH +: X_WIDTH];
                sel_y = req_y[i*Y_WIDTH +: Y_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register, pointer, owner and hold counter next-state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        prod_d  = prod_q;
        valid_d = 1'b0;
        if (clear) begin
            // Owner intentionally survives a clear: it names the last writer.
            cnt_d    = '0;
            ptr_d    = '0;
            prod_d.x = INIT_X;
            prod_d.y = INIT_Y;
        end else if (hs) begin
            prod_d.x = sel_x;
            prod_d.y = sel_y;
            valid_d  = 1'b1;
            owner_d  = pick_idx;
            ptr_d    = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt_d    = CNT_W'(HOLD_CYCLES);
        end else if (state_q == HOLD) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            cnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            prod_q.x <= INIT_X;
            prod_q.y <= INIT_Y;
            valid_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    assign O_x     = prod_q.x;
    assign O_y     = prod_q.y;
    assign O_valid = valid_q;
    assign O_owner = owner_q;

endmodule : product_reg_arbiter

// File: tb/tb_product_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_product_reg_arbiter
//
// Drives two arbiter instances (HOLD_CYCLES=2 and HOLD_CYCLES=0) from the same
// inputs. A time-based reference model tracks both; directed tables carry
// hand-derived expectations for the corner sequences.
// -----------------------------------------------------------------------------
module tb_product_reg_arbiter;

    import product_reg_pkg::*;

    localparam int N  = 4;
    localparam int XW = X_WIDTH;
    localparam int YW = Y_WIDTH;

    logic            CLK = 1'b0;
    logic            ASYNCRESETN;
    logic [N-1:0]    req_valid;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic            clear;

    logic [N-1:0]  rdy [2];
    logic [XW-1:0] ox  [2];
    logic [YW-1:0] oy  [2];
    logic          ov  [2];
    logic [1:0]    own [2];
    logic          bsy [2];

    always #5 CLK = ~CLK;

    product_reg_arbiter #(
        .N_REQ(N), .X_WIDTH(XW), .Y_WIDTH(YW),
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .HOLD_CYCLES(2)
    ) dut_h2 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_valid(req_valid), .req_ready(rdy[0]),
        .req_x(req_x), .req_y(req_y), .clear(clear),
        .O_x(ox[0]), .O_y(oy[0]), .O_valid(ov[0]), .O_owner(own[0]), .busy(bsy[0])
    );

    product_reg_arbiter #(
        .N_REQ(N), .X_WIDTH(XW), .Y_WIDTH(YW),
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .HOLD_CYCLES(0)
    ) dut_h0 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_valid(req_valid), .req_ready(rdy[1]),
        .req_x(req_x), .req_y(req_y), .clear(clear),
        .O_x(ox[1]), .O_y(oy[1]), .O_valid(ov[1]), .O_owner(own[1]), .busy(bsy[1])
    );

    // ---------------- reference model ----------------
    // Hold is modelled as "first cycle number at which a grant is allowed".
    int       cyc;
    int       m_ptr   [2];
    int       m_free  [2];
    int       m_owner [2];
    product_t m_reg   [2];
    logic     m_v     [2];

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [N-1:0]  v;
        logic          clr;
        logic [N-1:0]  rdy;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          vo;
        logic [1:0]    owner;
        logic          busy;
    } vec_t;

    vec_t tv[$];

    function automatic int hold_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int d);
        logic [N-1:0] r;
        int g;
        r = '0;
        if (ASYNCRESETN !== 1'b1 || clear || cyc < m_free[d]) return r;
        g = pick(req_valid, m_ptr[d]);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] v, input logic clr, input logic [N-1:0] r,
                                input logic [XW-1:0] x, input logic [YW-1:0] y, input logic vo,
                                input logic [1:0] owner, input logic busy);
        vec_t t;
        t.v = v; t.clr = clr; t.rdy = r; t.x = x; t.y = y;
        t.vo = vo; t.owner = owner; t.busy = busy;
        return t;
    endfunction

    task automatic model_reset_all();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]   = 0;
            m_free[d]  = 0;
            m_owner[d] = 0;
            m_reg[d].x = INIT_X;
            m_reg[d].y = INIT_Y;
            m_v[d]     = 1'b0;
        end
    endtask

    // Applied right after a rising edge, using the inputs that edge sampled.
    task automatic model_edge();
        int g;
        if (ASYNCRESETN !== 1'b1) begin
            model_reset_all();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            if (clear) begin
                m_reg[d].x = INIT_X;
                m_reg[d].y = INIT_Y;
                m_v[d]     = 1'b0;
                m_ptr[d]   = 0;
                m_free[d]  = cyc + 1;
            end else begin
                g = (cyc >= m_free[d]) ? pick(req_valid, m_ptr[d]) : -1;
                if (g >= 0) begin
                    m_reg[d].x = req_x[g*XW +: XW];
                    m_reg[d].y = req_y[g*YW +: YW];
                    m_v[d]     = 1'b1;
                    m_owner[d] = g;
                    m_ptr[d]   = (g + 1) % N;
                    m_free[d]  = cyc + 1 + hold_of(d);
                end else begin
                    m_v[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.ready", tag), d, 32'(rdy[d]), 32'(exp_ready(d)));
            chk($sformatf("%s.O_x", tag), d, 32'(ox[d]), 32'(m_reg[d].x));
            chk($sformatf("%s.O_y", tag), d, 32'(oy[d]), 32'(m_reg[d].y));
            chk($sformatf("%s.O_valid", tag), d, 32'(ov[d]), 32'(m_v[d]));
            chk($sformatf("%s.O_owner", tag), d, 32'(own[d]), 32'(m_owner[d]));
            chk($sformatf("%s.busy", tag), d, 32'(bsy[d]), 32'(cyc < m_free[d]));
        end
    endtask

    // One clock cycle: inputs applied now (just after a rising edge), outputs
    // sampled on the falling edge, model advanced at the next rising edge.
    task automatic step(input logic [N-1:0] v, input logic clr, input bit tbl,
                        input int d, input vec_t r, input string tag);
        req_valid = v;
        clear     = clr;
        @(negedge CLK);
        check_all(tag);
        if (tbl) begin
            chk($sformatf("%s.tbl_ready", tag), d, 32'(rdy[d]), 32'(r.rdy));
            chk($sformatf("%s.tbl_O_x", tag), d, 32'(ox[d]), 32'(r.x));
            chk($sformatf("%s.tbl_O_y", tag), d, 32'(oy[d]), 32'(r.y));
            chk($sformatf("%s.tbl_O_valid", tag), d, 32'(ov[d]), 32'(r.vo));
            chk($sformatf("%s.tbl_O_owner", tag), d, 32'(own[d]), 32'(r.owner));
            chk($sformatf("%s.tbl_busy", tag), d, 32'(bsy[d]), 32'(r.busy));
        end
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic run_table(input int d, input string tag);
        foreach (tv[i]) begin
            step(tv[i].v, tv[i].clr, 1'b1, d, tv[i], $sformatf("%s[%0d]", tag, i));
        end
        tv.delete();
    endtask

    // Mid-cycle reset pulse; must be called just after a rising edge.
    task automatic do_reset();
        #1 ASYNCRESETN = 1'b0;
        model_reset_all();
        #1 check_all("arst_pulse");
        #1 ASYNCRESETN = 1'b1;
    endtask

    task automatic lanes_seq();
        req_x = {8'h13, 8'h12, 8'h11, 8'h10};
        req_y = {4'h3, 4'h2, 4'h1, 4'h0};
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        ASYNCRESETN = 1'b1;
        clear     = 1'b0;
        req_valid = 4'b1111;
        lanes_seq();
        model_reset_all();

        // Reset asserted mid-cycle while every requester is asking.
        #2 ASYNCRESETN = 1'b0;
        #1 check_all("reset_immediate");
        chk("reset.ready", 0, 32'(rdy[0]), 32'h0);
        chk("reset.O_x", 0, 32'(ox[0]), 32'hde);
        chk("reset.O_y", 0, 32'(oy[0]), 32'ha);
        step(4'b1111, 1'b0, 1'b0, 0, '0, "in_reset0");
        step(4'b1111, 1'b0, 1'b0, 0, '0, "in_reset1");
        ASYNCRESETN = 1'b1;

        // Single write with a 2-cycle hold; others blocked while holding.
        req_x = {8'h23, 8'h22, 8'h12, 8'h20};
        req_y = {4'h6, 4'h5, 4'h3, 4'h0};
        tv.push_back(mk(4'b0010, 1'b0, 4'b0010, 8'hde, 4'ha, 1'b0, 2'd0, 1'b0));
        tv.push_back(mk(4'b1111, 1'b0, 4'b0000, 8'h12, 4'h3, 1'b1, 2'd1, 1'b1));
        tv.push_back(mk(4'b1111, 1'b0, 4'b0000, 8'h12, 4'h3, 1'b0, 2'd1, 1'b1));
        tv.push_back(mk(4'b1111, 1'b0, 4'b0100, 8'h12, 4'h3, 1'b0, 2'd1, 1'b0));
        tv.push_back(mk(4'b0000, 1'b0, 4'b0000, 8'h22, 4'h5, 1'b1, 2'd2, 1'b1));
        run_table(0, "single");

        // Back-to-back grants without hold, then wrap from 2 to {3, 0}.
        do_reset();
        lanes_seq();
        tv.push_back(mk(4'b1111, 1'b0, 4'b0001, 8'hde, 4'ha, 1'b0, 2'd0, 1'b0));
        tv.push_back(mk(4'b1111, 1'b0, 4'b0010, 8'h10, 4'h0, 1'b1, 2'd0, 1'b0));
        tv.push_back(mk(4'b1111, 1'b0, 4'b0100, 8'h11, 4'h1, 1'b1, 2'd1, 1'b0));
        tv.push_back(mk(4'b1111, 1'b0, 4'b1000, 8'h12, 4'h2, 1'b1, 2'd2, 1'b0));
        tv.push_back(mk(4'b1111, 1'b0, 4'b0001, 8'h13, 4'h3, 1'b1, 2'd3, 1'b0));
        tv.push_back(mk(4'b0100, 1'b0, 4'b0100, 8'h10, 4'h0, 1'b1, 2'd0, 1'b0));
        tv.push_back(mk(4'b1001, 1'b0, 4'b1000, 8'h12, 4'h2, 1'b1, 2'd2, 1'b0));
        tv.push_back(mk(4'b1001, 1'b0, 4'b0001, 8'h13, 4'h3, 1'b1, 2'd3, 1'b0));
        tv.push_back(mk(4'b0000, 1'b0, 4'b0000, 8'h10, 4'h0, 1'b1, 2'd0, 1'b0));
        tv.push_back(mk(4'b0000, 1'b0, 4'b0000, 8'h10, 4'h0, 1'b0, 2'd0, 1'b0));
        run_table(1, "b2b");

        // Clear during hold: aborts hold, reloads init, keeps owner, ptr to 0.
        do_reset();
        lanes_seq();
        tv.push_back(mk(4'b0100, 1'b0, 4'b0100, 8'hde, 4'ha, 1'b0, 2'd0, 1'b0));
        tv.push_back(mk(4'b0101, 1'b1, 4'b0000, 8'h12, 4'h2, 1'b1, 2'd2, 1'b1));
        tv.push_back(mk(4'b0101, 1'b0, 4'b0001, 8'hde, 4'ha, 1'b0, 2'd2, 1'b0));
        tv.push_back(mk(4'b0000, 1'b0, 4'b0000, 8'h10, 4'h0, 1'b1, 2'd0, 1'b1));
        run_table(0, "clear_hold");

        // Asynchronous reset while holding, then arbitration restarts at 0.
        do_reset();
        lanes_seq();
        step(4'b1000, 1'b0, 1'b1, 0, mk(4'b1000, 1'b0, 4'b1000, 8'hde, 4'ha, 1'b0, 2'd0, 1'b0), "arst_hold[0]");
        step(4'b1111, 1'b0, 1'b1, 0, mk(4'b1111, 1'b0, 4'b0000, 8'h13, 4'h3, 1'b1, 2'd3, 1'b1), "arst_hold[1]");
        chk("arst_hold.busy_before", 0, 32'(bsy[0]), 32'h1);
        #1 ASYNCRESETN = 1'b0;
        model_reset_all();
        #1;
        chk("arst_hold.busy", 0, 32'(bsy[0]), 32'h0);
        chk("arst_hold.O_x", 0, 32'(ox[0]), 32'hde);
        chk("arst_hold.O_y", 0, 32'(oy[0]), 32'ha);
        chk("arst_hold.ready", 0, 32'(rdy[0]), 32'h0);
        chk("arst_hold.O_valid", 0, 32'(ov[0]), 32'h0);
        check_all("arst_hold_mid");
        #1 ASYNCRESETN = 1'b1;
        step(4'b1001, 1'b0, 1'b1, 0, mk(4'b1001, 1'b0, 4'b0001, 8'hde, 4'ha, 1'b0, 2'd0, 1'b0), "arst_hold[2]");
        step(4'b0000, 1'b0, 1'b1, 0, mk(4'b0000, 1'b0, 4'b0000, 8'h10, 4'h0, 1'b1, 2'd0, 1'b1), "arst_hold[3]");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] v;
            req_x = (N*XW)'($urandom);
            req_y = (N*YW)'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) v = N'($urandom);
            else                           v = N'($urandom & $urandom);
            step(v, ($urandom_range(0, 19) == 0), 1'b0, 0, '0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_product_reg_arbiter

// File: doc/product_reg_arbiter.md
Name: product_reg_arbiter

Overview:
- Arbitrates N requesters that share one product-typed register holding fields x and y.
- Each cycle it grants at most one requester, using round-robin order, and loads that requester's {x,y} into the register.
- After each write it can hold the register stable for a programmable number of cycles before accepting the next write.
- Sits in front of the shared product register; downstream logic reads O_x/O_y and the O_valid update pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- X_WIDTH, 8, width of field x
- Y_WIDTH, 4, width of field y
- INIT_X, 8'hde, value of x on reset and on clear
- INIT_Y, 4'ha, value of y on reset and on clear
- HOLD_CYCLES, 2, cycles during which all grants are blocked after a write (0 allows back-to-back writes)

Ports:
- CLK  in  1  clock, rising edge
- ASYNCRESETN  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester write request
- req_ready  out  N_REQ  per-requester grant; one-hot or zero
- req_x  in  N_REQ*X_WIDTH  packed x fields; requester i occupies [i*X_WIDTH +: X_WIDTH]
- req_y  in  N_REQ*Y_WIDTH  packed y fields, same packing
- clear  in  1  synchronous reload of the INIT values
- O_x  out  X_WIDTH  registered field x
- O_y  out  Y_WIDTH  registered field y
- O_valid  out  1  one-cycle pulse: register was updated at the last edge
- O_owner  out  $clog2(N_REQ)  index of the last granted requester
- busy  out  1  high while in HOLD

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on ASYNCRESETN.
- Reset values, applied immediately when ASYNCRESETN is low:
  - O_x=INIT_X, O_y=INIT_Y
  - O_valid=0, O_owner=0, busy=0
  - rr pointer=0, hold counter=0, state=IDLE
  - req_ready=0 for as long as ASYNCRESETN is low
- State machine:
  - IDLE to HOLD on a handshake when HOLD_CYCLES>0.
  - HOLD to IDLE when the hold counter equals 1 at the edge.
  - Any state to IDLE on clear.
- Arbitration (IDLE only, clear low):
  - Winner g is the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; every other ready bit is 0.
  - No valid request means no grant, and state is unchanged.
- Handshake = req_valid[g] & req_ready[g]. At the following edge:
  - O_x/O_y take requester g's fields.
  - O_valid goes to 1 for exactly one cycle.
  - O_owner=g.
  - ptr=(g+1) mod N_REQ.
  - If HOLD_CYCLES>0, the hold counter loads HOLD_CYCLES and state goes to HOLD.
  - If HOLD_CYCLES=0, state stays IDLE, and a write can complete every cycle.
- Latency: data accepted in cycle t appears on O_x/O_y in cycle t+1, with O_valid=1 in t+1.
- HOLD:
  - req_ready=0 for all requesters and busy=1.
  - The counter decrements every edge; at counter==1 state returns to IDLE.
  - HOLD therefore lasts exactly HOLD_CYCLES cycles.
  - The first new grant comes HOLD_CYCLES+1 cycles after the accepting cycle.
- clear (synchronous, highest priority):
  - In the clear cycle, req_ready=0 and no handshake occurs.
  - At the next edge: O_x=INIT_X, O_y=INIT_Y, O_valid=0, state=IDLE, counter=0, ptr=0.
  - O_owner is unchanged.
  - Clear in HOLD aborts the hold.
- Requester protocol: a requester holds req_valid and its data stable until granted. The arbiter does not check this.
- Deasserting valid: a requester that drops valid before its grant loses its turn without side effects.
- Reset mid-HOLD: all state returns to the reset values above; the next arbitration starts from ptr=0.
- Fairness: each continuously requesting requester is granted within N_REQ grants.

Decomposition:
- Package product_reg_pkg holds:
  - X_WIDTH, Y_WIDTH, INIT_X, INIT_Y
  - typedef product_t {x, y}, packed with y in the MSBs and x in the LSBs
  - state enum {IDLE, HOLD}
- Sub-module product_rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded index, any flag.
- The top level contains the FSM, hold counter, pointer and the product_t register.

Test Plan:
- Reset: assert ASYNCRESETN low mid-cycle with req_valid=4'b1111 -> immediately O_x=0xde, O_y=0xa, req_ready=0, O_valid=0, busy=0.
- Single write: HOLD_CYCLES=2, req_valid[1]=1 with x=0x12, y=0x3 -> req_ready=4'b0010 for one cycle. Next cycle: O_x=0x12, O_y=0x3, O_valid=1, O_owner=1, busy=1 for 2 cycles with req_ready=0.
- Back-to-back: HOLD_CYCLES=0, all four requesters valid continuously with x=0x10+i -> grants 0,1,2,3,0 on consecutive cycles. O_x reads 0x10, 0x11, 0x12, 0x13, 0x10 one cycle later each; O_valid is held high.
- Wrap: after a grant to 2, only requesters 0 and 3 are valid -> grant 3, then grant 0.
- Clear in HOLD: clear=1 during HOLD while req_valid[0]=1 -> no ready in that cycle. Next cycle: O_x=0xde, O_y=0xa, busy=0, O_valid=0. The following cycle grants requester 0.
- Async reset in HOLD: ASYNCRESETN pulsed low while busy=1 -> busy=0 immediately, O_x/O_y back to init. After release, requesters 3 and 0 both valid -> grant 0.
